// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state type and sizing helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } stateT;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Counter must hold every value up to WIDTH.
    function automatic int cntWidth(input int width);
        return clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_iter_core.sv
// One restoring radix-2 division step: shift in the next dividend bit, trial subtract, pick quotient bit.
module div_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The partial remainder stays below the divisor, so one extra bit covers the shifted value.
    assign shifted = {remIn, quoIn[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};

    assign remOut = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quoOut = {quoIn[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/muldiv_iter.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing a HI/LO pair with a combinational pipeline stall.
// Optional MULDIV_EARLY_OUT_EN: divides with a zero or oversized divisor finish one cycle after start.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CntW = cntWidth(WIDTH);
    localparam logic [CntW-1:0] MulLast = CntW'(MUL_LATENCY - 1);
    localparam logic [CntW-1:0] DivLast = CntW'(WIDTH - 1);

    stateT state;
    stateT stateNext;

    logic [CntW-1:0]  cnt;
    logic             opSigned;
    logic             negQ;
    logic             negR;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic [WIDTH-1:0] dvsReg;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quoNext;
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    logic             divZeroReg;

    logic             inSigned;
    logic             inDiv;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;
    logic             earlyOut;

    logic             capture;
    logic             mulFinish;
    logic             divFinish;
    logic             earlyFire;

    logic [2*WIDTH-1:0] mulA;
    logic [2*WIDTH-1:0] mulB;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quoFinal;
    logic [WIDTH-1:0]   remFinal;

    assign inSigned = (op == OP_MULT) || (op == OP_DIV);
    assign inDiv    = (op == OP_DIV) || (op == OP_DIVU);
    assign magA     = (inSigned && a[WIDTH-1]) ? -a : a;
    assign magB     = (inSigned && b[WIDTH-1]) ? -b : b;

`ifdef MULDIV_EARLY_OUT_EN
    assign earlyOut = inDiv && ((b == '0) || (magB > magA));
`else
    assign earlyOut = 1'b0;
`endif

    // Product of the captured operands; the MUL cycles give it time to settle or be retimed.
    assign mulA    = {{WIDTH{opSigned & aReg[WIDTH-1]}}, aReg};
    assign mulB    = {{WIDTH{opSigned & bReg[WIDTH-1]}}, bReg};
    assign product = mulA * mulB;

    div_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .remIn  (remReg),
        .quoIn  (quoReg),
        .divisor(dvsReg),
        .remOut (remNext),
        .quoOut (quoNext)
    );

    assign quoFinal = negQ ? -quoNext : quoNext;
    assign remFinal = negR ? -remNext : remNext;

    always_comb begin
        stateNext = state;
        stall     = 1'b0;
        done      = 1'b0;
        capture   = 1'b0;
        mulFinish = 1'b0;
        divFinish = 1'b0;
        earlyFire = 1'b0;
        case (state)
            IDLE: begin
                if (start && !cancel && rst) begin
                    stall   = 1'b1;
                    capture = 1'b1;
                    if (inDiv) begin
                        earlyFire = earlyOut;
                        stateNext = earlyOut ? DONE : DIV;
                    end else begin
                        stateNext = MUL;
                    end
                end
            end
            MUL: begin
                if (cancel) begin
                    stateNext = IDLE;
                end else begin
                    stall = 1'b1;
                    if (cnt == MulLast) begin
                        mulFinish = 1'b1;
                        stateNext = DONE;
                    end
                end
            end
            DIV: begin
                if (cancel) begin
                    stateNext = IDLE;
                end else begin
                    stall = 1'b1;
                    if (cnt == DivLast) begin
                        divFinish = 1'b1;
                        stateNext = DONE;
                    end
                end
            end
            DONE: begin
                done      = !cancel;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            opSigned   <= 1'b0;
            negQ       <= 1'b0;
            negR       <= 1'b0;
            aReg       <= '0;
            bReg       <= '0;
            dvsReg     <= '0;
            remReg     <= '0;
            quoReg     <= '0;
            hiReg      <= '0;
            loReg      <= '0;
            divZeroReg <= 1'b0;
        end else begin
            state <= stateNext;
            if (capture) begin
                cnt      <= '0;
                opSigned <= inSigned;
                negQ     <= inSigned & (a[WIDTH-1] ^ b[WIDTH-1]);
                negR     <= inSigned & a[WIDTH-1];
                aReg     <= a;
                bReg     <= b;
                dvsReg   <= magB;
                remReg   <= '0;
                quoReg   <= magA;
            end else if (state == MUL || state == DIV) begin
                cnt <= cnt + 1'b1;
            end
            if (state == DIV) begin
                remReg <= remNext;
                quoReg <= quoNext;
            end
            if (mulFinish) begin
                hiReg      <= product[2*WIDTH-1:WIDTH];
                loReg      <= product[WIDTH-1:0];
                divZeroReg <= 1'b0;
            end
            // A zero divisor reports all-ones quotient and the untouched dividend.
            if (divFinish) begin
                if (dvsReg == '0) begin
                    loReg      <= '1;
                    hiReg      <= aReg;
                    divZeroReg <= 1'b1;
                end else begin
                    loReg      <= quoFinal;
                    hiReg      <= remFinal;
                    divZeroReg <= 1'b0;
                end
            end
            if (earlyFire) begin
                hiReg      <= a;
                loReg      <= (b == '0) ? '1 : '0;
                divZeroReg <= (b == '0);
            end
        end
    end

    assign hi       = hiReg;
    assign lo       = loReg;
    assign div_zero = divZeroReg;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter (WIDTH=32, MUL_LATENCY=2); honours MULDIV_EARLY_OUT_EN.
module tb_muldiv_iter;

    localparam int W = 32;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EarlyCyc = 1;
`else
    localparam int EarlyCyc = 33;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic         cancel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         stall;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_zero;

    int total;
    int bad;

    muldiv_iter #(
        .WIDTH(W),
        .MUL_LATENCY(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .cancel  (cancel),
        .a       (a),
        .b       (b),
        .stall   (stall),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a request in the next cycle (cycle 0) and checks the same-cycle stall.
    task automatic startOp(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        tick();
        start  = 1'b1;
        cancel = 1'b0;
        op     = o;
        a      = x;
        b      = y;
        #1;
        check("stall_start", {63'd0, stall}, 64'd1);
    endtask

    task automatic runOp(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input int expCyc, input logic [W-1:0] expHi,
                         input logic [W-1:0] expLo, input logic expDz);
        int cyc;
        bit got;
        startOp(o, x, y);
        cyc = 0;
        got = 1'b0;
        while (cyc < 60 && !got) begin
            tick();
            start = 1'b0;
            cyc++;
            if (done) got = 1'b1;
            else check({tag, "_busy_stall"}, {63'd0, stall}, 64'd1);
        end
        check({tag, "_cycle"}, 64'(cyc), 64'(expCyc));
        check({tag, "_done_stall"}, {63'd0, stall}, 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(expHi));
        check({tag, "_lo"}, 64'(lo), 64'(expLo));
        check({tag, "_dz"}, {63'd0, div_zero}, {63'd0, expDz});
    endtask

    initial begin
        bit sawDone;
        total  = 0;
        bad    = 0;
        rst    = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        #2;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_dz", {63'd0, div_zero}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        runOp("mult", 2'b00, 32'hFFFF_FFFE, 32'd3, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        runOp("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        runOp("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        runOp("div_negb", 2'b10, 32'd7, 32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        runOp("divu_zero", 2'b11, 32'd100, 32'd0, EarlyCyc, 32'd100, 32'hFFFF_FFFF, 1'b1);
        runOp("div_min", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000, 1'b0);
        runOp("div_szero", 2'b10, 32'hFFFF_FFF9, 32'd0, EarlyCyc, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        runOp("divu_small", 2'b11, 32'd5, 32'd9, EarlyCyc, 32'd5, 32'd0, 1'b0);

        // start together with cancel in IDLE must be ignored
        tick();
        start  = 1'b1;
        cancel = 1'b1;
        op     = 2'b00;
        a      = 32'd2;
        b      = 32'd2;
        #1;
        check("sc_stall", {63'd0, stall}, 64'd0);
        sawDone = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            start  = 1'b0;
            cancel = 1'b0;
            if (done || stall) sawDone = 1'b1;
        end
        check("sc_idle", {63'd0, sawDone}, 64'd0);

        // cancel a divide at cycle 10, restart at cycle 11
        startOp(2'b11, 32'd10, 32'd3);
        sawDone = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            start = 1'b0;
            if (done) sawDone = 1'b1;
        end
        tick();
        cancel = 1'b1;
        #1;
        check("cancel_stall", {63'd0, stall}, 64'd0);
        check("cancel_done", {63'd0, done | sawDone}, 64'd0);
        check("cancel_hi", 64'(hi), 64'd5);
        check("cancel_lo", 64'(lo), 64'd0);
        runOp("after_cancel", 2'b11, 32'd10, 32'd3, 33, 32'd1, 32'd3, 1'b0);

        // asynchronous reset in the middle of a divide
        startOp(2'b11, 32'd10, 32'd3);
        for (int c = 1; c <= 5; c++) begin
            tick();
            start = 1'b0;
        end
        rst = 1'b0;
        #1;
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_stall", {63'd0, stall}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        runOp("post_rst", 2'b00, 32'd3, 32'd4, 3, 32'd0, 32'd12, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
